pov_spi_loader: RTL and testbench
=================================

// Module: pov_spi_loader
// PURPOSE
//  Upstream source of the view vectors (playerX/Y, facingX/Y, vplaneX/Y) consumed by the
//  wall tracer, map overlay and debug overlay; replaces the constant POV block. An external
//  host shifts one 6-vector frame in over a slow SPI-like link. The frame is held in a
//  pending buffer and committed to the outputs only on a vsync rising edge, so a rendered
//  frame never sees torn vectors.
// PARAMETERS
//  W        16       width of each fixed-point vector component (Q6.10, 1.0 = 16'h0400)
//  RST_PX   16'h0600 reset playerX (1.5)
//  RST_PY   16'h0600 reset playerY (1.5)
//  RST_FX   16'h0000 reset facingX (0.0)
//  RST_FY   16'h0400 reset facingY (1.0)
//  RST_VX   16'hFE00 reset vplaneX (-0.5)
//  RST_VY   16'h0000 reset vplaneY (0.0)
// PORTS
//  clk        in   1    pixel clock; all logic in this domain
//  reset      in   1    asynchronous, active-low reset
//  i_sclk     in   1    SPI clock from host, async; must be <= clk/4
//  i_mosi     in   1    SPI data, async; sampled on i_sclk rising edge
//  i_ss_n     in   1    SPI select, active-low, async; frames one transfer
//  vsync      in   1    active-high vsync from vga_sync; commit on its rising edge
//  playerX    out  W    committed player X
//  playerY    out  W    committed player Y
//  facingX    out  W    committed facing X
//  facingY    out  W    committed facing Y
//  vplaneX    out  W    committed view-plane X
//  vplaneY    out  W    committed view-plane Y
//  o_pending  out  1    1 = complete frame waiting for next vsync commit
//  o_err      out  1    1-cycle pulse: transfer ended with bit count != 6*W
// BEHAVIOUR
//  - Reset (reset=0): outputs = RST_* values; pending buffer = RST_*; o_pending=0, o_err=0,
//    bit counter=0, synchronisers cleared to idle (sclk=0, ss_n=1, vsync=0).
//  - i_sclk, i_mosi, i_ss_n, vsync each pass a 2-FF synchroniser; edges are detected on
//    synchronised values (3rd flop). Edge-to-action latency is 3 clk.
//  - Shift: while ss_n_s=0, each sclk_s rising edge shifts mosi_s into the LSB of a 6*W
//    shift register (MSB first overall; order playerX, playerY, facingX, facingY, vplaneX,
//    vplaneY) and increments the bit counter (saturates at 6*W+1).
//  - ss_n_s falling edge: bit counter cleared; shift register contents don't-care.
//  - ss_n_s rising edge: if count==6*W, copy shift register to pending buffer and set
//    o_pending=1. Otherwise pending buffer untouched, o_err pulses high for 1 cycle.
//  - Overrun: a valid frame arriving while o_pending=1 overwrites the pending buffer;
//    o_pending stays 1; no error.
//  - Commit: on vsync_s rising edge with o_pending=1, outputs <= pending buffer, o_pending<=0.
//    With o_pending=0, outputs hold.
//  - Same cycle vsync rise + valid ss_n rise: commit uses the pre-existing pending buffer
//    (if o_pending was 1), then the new frame loads pending and o_pending ends the cycle at 1.
//    If o_pending was 0, nothing commits; new frame pending.
//  - Outputs change only on commit cycles (glitch-free registered outputs).
//  - Reset mid-transfer: partial frame discarded; after reset the host must drop and re-assert
//    ss_n.
// TESTING
//  1 Reset release -> playerX=0x0600, facingY=0x0400, vplaneX=0xFE00, o_pending=0.
//  2 Shift 96 bits {0x0800,0x0A00,0x0400,0x0000,0x0000,0xFE00}, no vsync -> o_pending=1,
//    outputs still reset values; vsync rise -> outputs = frame within 4 clk, o_pending=0.
//  3 Transfer of 95 bits then ss_n high -> o_err pulses exactly 1 cycle, pending/outputs unchanged;
//    repeat with 97 bits -> same.
//  4 Two valid frames A then B before vsync -> single vsync commits B; second vsync no change.
//  5 Arrange vsync_s rise and ss_n_s rise on the same clk, o_pending=1 with frame A, new
//    frame B -> outputs=A, o_pending=1; next vsync -> outputs=B.
//  6 Assert reset mid-transfer (after 40 bits) -> all reset values; full fresh frame then
//    loads and commits correctly.

Source files
------------

// File: rtl/pov_spi_loader.sv
// View-vector loader: host shifts a 6-component frame over a slow SPI-like link;
// the frame is held pending and committed to the outputs on the next vsync rise.
module pov_spi_loader #(
  parameter int W                 = 16,
  parameter logic [W-1:0] RST_PX  = 16'h0600,
  parameter logic [W-1:0] RST_PY  = 16'h0600,
  parameter logic [W-1:0] RST_FX  = 16'h0000,
  parameter logic [W-1:0] RST_FY  = 16'h0400,
  parameter logic [W-1:0] RST_VX  = 16'hFE00,
  parameter logic [W-1:0] RST_VY  = 16'h0000
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_sclk,
  input  logic         i_mosi,
  input  logic         i_ss_n,
  input  logic         vsync,
  output logic [W-1:0] playerX,
  output logic [W-1:0] playerY,
  output logic [W-1:0] facingX,
  output logic [W-1:0] facingY,
  output logic [W-1:0] vplaneX,
  output logic [W-1:0] vplaneY,
  output logic         o_pending,
  output logic         o_err
);

  localparam int FW = 6 * W;
  localparam int CW = $clog2(FW + 2);
  localparam logic [FW-1:0] RST_FRAME = {RST_PX, RST_PY, RST_FX, RST_FY, RST_VX, RST_VY};
  localparam logic [CW-1:0] CNT_FULL  = CW'(FW);
  localparam logic [CW-1:0] CNT_SAT   = CW'(FW + 1);

  // [0],[1] synchronise; [2] is the previous synchronised value for edge detection
  logic [2:0]    sclk_q, ss_q, vs_q;
  logic [1:0]    mosi_q;
  logic [FW-1:0] shreg, pend_buf, out_q;
  logic [CW-1:0] bit_cnt;

  logic sclk_rise, ss_fall, ss_rise, vs_rise, frame_ok, commit;

  always_comb begin
    sclk_rise = sclk_q[1] & ~sclk_q[2];
    ss_fall   = ~ss_q[1] & ss_q[2];
    ss_rise   = ss_q[1] & ~ss_q[2];
    vs_rise   = vs_q[1] & ~vs_q[2];
    frame_ok  = ss_rise && (bit_cnt == CNT_FULL);
    commit    = vs_rise && o_pending;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sclk_q <= '0;
      ss_q   <= '1;
      vs_q   <= '0;
      mosi_q <= '0;
    end else begin
      sclk_q <= {sclk_q[1:0], i_sclk};
      ss_q   <= {ss_q[1:0], i_ss_n};
      vs_q   <= {vs_q[1:0], vsync};
      mosi_q <= {mosi_q[0], i_mosi};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shreg   <= '0;
      bit_cnt <= '0;
    end else if (ss_fall) begin
      bit_cnt <= '0;
    end else if (!ss_q[1] && sclk_rise) begin
      shreg <= {shreg[FW-2:0], mosi_q[1]};
      if (bit_cnt != CNT_SAT)
        bit_cnt <= bit_cnt + 1'b1;
    end
  end

  // Commit reads the old pending buffer while a simultaneous valid frame
  // overwrites it, so a same-cycle vsync never shows the newer frame early.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pend_buf  <= RST_FRAME;
      out_q     <= RST_FRAME;
      o_pending <= 1'b0;
      o_err     <= 1'b0;
    end else begin
      o_err <= ss_rise && !frame_ok;
      if (commit)
        out_q <= pend_buf;
      if (frame_ok)
        pend_buf <= shreg;
      if (frame_ok)
        o_pending <= 1'b1;
      else if (commit)
        o_pending <= 1'b0;
    end
  end

  assign playerX = out_q[6*W-1 -: W];
  assign playerY = out_q[5*W-1 -: W];
  assign facingX = out_q[4*W-1 -: W];
  assign facingY = out_q[3*W-1 -: W];
  assign vplaneX = out_q[2*W-1 -: W];
  assign vplaneY = out_q[W-1 -: W];

endmodule

// File: tb/tb_pov_spi_loader.sv
// Directed bench for pov_spi_loader: behavioural frame model plus a scoreboard
// queue of expected committed outputs checked after each vsync.
module tb_pov_spi_loader;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        i_sclk = 1'b0;
  logic        i_mosi = 1'b0;
  logic        i_ss_n = 1'b1;
  logic        vsync = 1'b0;
  logic [15:0] playerX, playerY, facingX, facingY, vplaneX, vplaneY;
  logic        o_pending, o_err;

  pov_spi_loader #(.W(16)) dut (
    .clk(clk), .reset(reset), .i_sclk(i_sclk), .i_mosi(i_mosi), .i_ss_n(i_ss_n),
    .vsync(vsync), .playerX(playerX), .playerY(playerY), .facingX(facingX),
    .facingY(facingY), .vplaneX(vplaneX), .vplaneY(vplaneY),
    .o_pending(o_pending), .o_err(o_err)
  );

  always #5 clk = ~clk;

  localparam logic [95:0] RST_F = {16'h0600, 16'h0600, 16'h0000, 16'h0400, 16'hFE00, 16'h0000};

  typedef struct {
    logic [95:0] outs;
    logic        pend;
    string       tag;
  } exp_t;

  exp_t        sb[$];
  int          n_cmp = 0;
  int          n_err = 0;
  int          err_hi = 0;
  logic [95:0] m_out, m_buf;
  logic        m_pending;

  always @(negedge clk) if (o_err === 1'b1) err_hi++;

  function automatic logic [95:0] outs();
    return {playerX, playerY, facingX, facingY, vplaneX, vplaneY};
  endfunction

  task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic wclk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic spi_bit(input logic b);
    i_mosi = b;
    wclk(4);
    i_sclk = 1'b1;
    wclk(4);
    i_sclk = 1'b0;
  endtask

  // Shift n bits of f MSB-first; bits past 96 are zeros. Leaves ss_n low if !close.
  task automatic shift(input logic [95:0] f, input int n, input bit close);
    i_ss_n = 1'b0;
    wclk(6);
    for (int i = 0; i < n; i++) spi_bit(i < 96 ? f[95 - i] : 1'b0);
    wclk(4);
    if (close) begin
      i_ss_n = 1'b1;
      if (n == 96) begin
        m_buf = f;
        m_pending = 1'b1;
      end
      wclk(6);
    end
  endtask

  task automatic sb_check();
    exp_t e;
    if (sb.size() == 0) begin
      n_cmp++; n_err++;
      $error("FAIL scoreboard_empty observed=0 expected=1");
    end else begin
      e = sb.pop_front();
      chk({e.tag, "_outs"}, outs(), e.outs);
      chk({e.tag, "_pend"}, 96'(o_pending), 96'(e.pend));
    end
  endtask

  task automatic vsync_pulse(input string tag);
    exp_t e;
    vsync = 1'b1;
    if (m_pending) begin
      m_out = m_buf;
      m_pending = 1'b0;
    end
    e.outs = m_out; e.pend = m_pending; e.tag = tag;
    sb.push_back(e);
    wclk(4);
    sb_check();
    vsync = 1'b0;
    wclk(4);
  endtask

  task automatic model_reset();
    m_out = RST_F; m_buf = RST_F; m_pending = 1'b0;
  endtask

  logic [95:0] f2, fa, fb, fc;
  int          e0;
  exp_t        ex;

  initial begin
    f2 = {16'h0800, 16'h0A00, 16'h0400, 16'h0000, 16'h0000, 16'hFE00};
    fa = {16'h1000, 16'h1100, 16'h0000, 16'h0400, 16'h0200, 16'h0000};
    fb = {$urandom(), $urandom(), $urandom()};
    fc = {$urandom(), $urandom(), $urandom()};
    model_reset();
    wclk(3);
    reset = 1'b1;
    wclk(2);

    // 1: reset values
    chk("rst_playerX", 96'(playerX), 96'h0600);
    chk("rst_facingY", 96'(facingY), 96'h0400);
    chk("rst_vplaneX", 96'(vplaneX), 96'hFE00);
    chk("rst_outs", outs(), RST_F);
    chk("rst_pending", 96'(o_pending), 96'h0);

    // 2: valid frame held until vsync
    e0 = err_hi;
    shift(f2, 96, 1'b1);
    chk("t2_pending", 96'(o_pending), 96'h1);
    chk("t2_outs_hold", outs(), m_out);
    chk("t2_no_err", 96'(err_hi - e0), 96'h0);
    vsync_pulse("t2_commit");

    // 3: short and long transfers are rejected with one-cycle error pulse
    e0 = err_hi;
    shift(fa, 95, 1'b1);
    chk("t3_err95", 96'(err_hi - e0), 96'h1);
    chk("t3_pend95", 96'(o_pending), 96'h0);
    vsync_pulse("t3_nocommit95");
    e0 = err_hi;
    shift(fa, 97, 1'b1);
    chk("t3_err97", 96'(err_hi - e0), 96'h1);
    chk("t3_pend97", 96'(o_pending), 96'h0);
    vsync_pulse("t3_nocommit97");

    // 4: overrun, last frame wins
    e0 = err_hi;
    shift(fa, 96, 1'b1);
    shift(fb, 96, 1'b1);
    chk("t4_no_err", 96'(err_hi - e0), 96'h0);
    chk("t4_pending", 96'(o_pending), 96'h1);
    vsync_pulse("t4_commitB");
    vsync_pulse("t4_hold");

    // 5: vsync rise and ss_n rise land on the same clock
    shift(fa, 96, 1'b1);
    shift(fc, 96, 1'b0);
    vsync = 1'b1;
    i_ss_n = 1'b1;
    if (m_pending) begin
      m_out = m_buf;
      m_pending = 1'b0;
    end
    m_buf = fc; m_pending = 1'b1;
    ex.outs = m_out; ex.pend = m_pending; ex.tag = "t5_same";
    sb.push_back(ex);
    wclk(6);
    sb_check();
    chk("t5_outs_is_A", outs(), fa);
    vsync = 1'b0;
    wclk(4);
    vsync_pulse("t5_commitB");

    // 6: reset in mid transfer
    shift(fb, 40, 1'b0);
    reset = 1'b0;
    wclk(2);
    model_reset();
    chk("t6_rst_outs", outs(), RST_F);
    chk("t6_rst_pend", 96'(o_pending), 96'h0);
    i_ss_n = 1'b1;
    wclk(2);
    reset = 1'b1;
    wclk(4);
    vsync_pulse("t6_nocommit");
    shift(f2, 96, 1'b1);
    chk("t6_pending", 96'(o_pending), 96'h1);
    vsync_pulse("t6_commit");

    chk("sb_drained", 96'(sb.size()), 96'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
